lc4_div_seq: RTL
================

Name: lc4_div_seq

Overview:
- Multi-cycle sequencer for the LC4 DIV/MOD operation. It replaces the single-cycle combinational divider when the pipeline timing budget cannot absorb it.
- Runs an iterative restoring division: one shared subtract/compare stage, driven by a small FSM and an iteration counter.
- Sits beside the ALU in the execute stage. The stall logic uses o_busy; writeback captures the result on o_done.

Parameters:
- BITS_PER_CYCLE, 1, quotient bits resolved per clock. Legal values are 1, 2, 4; others are a compile-time error. Iteration count N = 16 / BITS_PER_CYCLE.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- i_start  input  1  request a division. Sampled only in IDLE.
- i_flush  input  1  squash the in-flight division (pipeline flush)
- i_dividend  input  16  unsigned dividend (rs)
- i_divisor  input  16  unsigned divisor (rt)
- o_busy  output  1  high in RUN and DONE; the stall request
- o_done  output  1  one-cycle pulse; results are valid this cycle
- o_quotient  output  16  quotient; held until the next accepted start
- o_remainder  output  16  remainder; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On rst, all state clears:
  - state = IDLE
  - o_busy = 0, o_done = 0
  - o_quotient = 0, o_remainder = 0
  - internal remainder, quotient, divisor and counter registers = 0
- States:
  - IDLE: waits for a request.
  - RUN: iterates.
  - DONE: presents the result for one cycle.
- IDLE, i_start=1, i_divisor!=0 (cycle T):
  - latch the dividend into the quotient shift register and the divisor into the divisor register
  - clear the partial remainder (17 bits) and set counter = N
  - next state = RUN
- IDLE, i_start=1, i_divisor==0:
  - go directly to DONE at T+1 with quotient = 0 and remainder = 0 (LC4 divide-by-zero rule)
  - no RUN cycles are spent
- RUN, per cycle, for each of BITS_PER_CYCLE sub-steps:
  - rem = {rem[15:0], q_msb}; q <<= 1
  - if rem >= divisor: rem = rem - divisor and q[0] = 1
  - after the sub-steps, decrement counter; when counter reaches 1, next state = DONE
- Latency: divisor!=0 gives o_done at cycle T+N+1 (T+17 when BITS_PER_CYCLE=1). Divisor==0 gives o_done at T+1.
- DONE:
  - o_done = 1 for exactly one cycle
  - o_quotient and o_remainder update at entry to DONE and hold through IDLE
  - next state = IDLE, unconditionally
- i_start outside IDLE is ignored. There is no queueing and the operands are not re-sampled.
- Operand inputs are don't-care except in the cycle where IDLE has i_start=1.
- i_flush:
  - in RUN or DONE: next state = IDLE, o_done is forced 0 that cycle, and the output registers keep their previous values
  - in IDLE: i_flush wins over i_start (the request is dropped)
- rst mid-operation: returns to IDLE immediately (asynchronous). Outputs go to 0 and no o_done is issued.
- Arithmetic is unsigned 16-bit throughout. The remainder compare uses 17 bits so the shifted-in carry is never lost.
- Invariants (the bench asserts these):
  - o_done implies o_busy
  - o_done is never high on two consecutive cycles
  - whenever o_done=1 with divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor

Test Plan:
- Reset, then start with 100/7 -> o_busy=1 from T+1; o_done at T+17 with quotient=14, remainder=2; o_busy=0 at T+18.
- Start with 0xFFFF/0x0001, then 0x1234/0xFFFF -> (0xFFFF, 0) and then (0, 0x1234). Outputs hold between the two operations.
- Start with 5/0 -> o_done at T+1, quotient=0, remainder=0; no RUN cycles.
- Start with 50/3, pulse i_start with 9/9 at T+5, then assert i_flush at T+8 -> no o_done; outputs retain their old values; a new start at T+10 with 9/9 gives (1, 0) at T+27.
- Assert rst asynchronously (mid-cycle) at T+6 of 1000/10 -> state is IDLE immediately; all outputs 0; no o_done pulse afterward.
- BITS_PER_CYCLE=4, random sweep of 10k operand pairs against the reference model -> o_done always at T+5; results match the model; invariants hold.

Source files
------------

// File: rtl/lc4_div_seq.sv
// rtl/lc4_div_seq.sv - multi-cycle restoring divider for LC4 DIV/MOD
module lc4_div_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder
);

    localparam int         N     = 16 / BITS_PER_CYCLE;
    localparam logic [4:0] N_CNT = 5'(N);

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
            $error("lc4_div_seq: BITS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_rem;
    logic [15:0] r_quo;
    logic [15:0] r_div;
    logic [4:0]  r_cnt;
    logic [15:0] r_q_out;
    logic [15:0] r_r_out;

    logic [16:0] w_rem_step;
    logic [15:0] w_quo_step;
    logic        w_load;
    logic        w_zero_done;
    logic        w_finish;
    logic        w_iterate;

    // Shared subtract/compare stage, unrolled BITS_PER_CYCLE times per clock.
    // The 17-bit partial remainder keeps the shifted-in bit for the compare.
    always_comb begin
        w_rem_step = {1'b0, r_rem};
        w_quo_step = r_quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_rem_step = {w_rem_step[15:0], w_quo_step[15]};
            w_quo_step = {w_quo_step[14:0], 1'b0};
            if (w_rem_step >= {1'b0, r_div}) begin
                w_rem_step    = w_rem_step - {1'b0, r_div};
                w_quo_step[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_zero_done = 1'b0;
        w_finish    = 1'b0;
        w_iterate   = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A flush in the same cycle drops the request.
                if (i_start && !i_flush) begin
                    if (i_divisor == 16'd0) begin
                        w_next      = S_DONE;
                        w_zero_done = 1'b1;
                    end else begin
                        w_next = S_RUN;
                        w_load = 1'b1;
                    end
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (i_flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_iterate = 1'b1;
                    if (r_cnt == 5'd1) begin
                        w_next   = S_DONE;
                        w_finish = 1'b1;
                    end
                end
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = !i_flush;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= 16'd0;
            r_quo <= 16'd0;
            r_div <= 16'd0;
            r_cnt <= 5'd0;
        end else if (w_load) begin
            r_rem <= 16'd0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= N_CNT;
        end else if (w_iterate) begin
            r_rem <= w_rem_step[15:0];
            r_quo <= w_quo_step;
            r_cnt <= r_cnt - 5'd1;
        end
    end

    // Result registers change only on entry to DONE; a flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_out <= 16'd0;
            r_r_out <= 16'd0;
        end else if (w_zero_done) begin
            r_q_out <= 16'd0;
            r_r_out <= 16'd0;
        end else if (w_finish) begin
            r_q_out <= w_quo_step;
            r_r_out <= w_rem_step[15:0];
        end
    end

    assign o_quotient  = r_q_out;
    assign o_remainder = r_r_out;

endmodule
